cache_mem_bridge: RTL and testbench

Line-transfer engine between the cache controller and main memory. It accepts one line-level miss request: an optional dirty-line writeback, then a mandatory refill. It sequences the request as single-word memory transactions over a ready-handshaked memory port, then returns the refilled line with a one-cycle response pulse. It supplies the memory-ready signal the cache controller uses to stall during miss handling.

---
 rtl/cache_mem_bridge.sv | 152 +++++++++++++++
 tb/tb_cache_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: line-transfer engine between the cache controller and
// main memory. One miss request is turned into an optional line writeback
// followed by a line refill, issued as single-word memory transactions, and
// completed with a one-cycle resp_valid pulse carrying the refilled line.
module cache_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wb,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_line,
  input  logic [ADDR_WIDTH-1:0]            rf_addr,
  output logic                             resp_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rf_line,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready
);

  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFS = CW + 2;
  localparam int HW  = ADDR_WIDTH - OFS;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, RF, DONE} state_t;

  state_t                           state_q;
  logic [CW-1:0]                    cnt_q;
  logic [CW-1:0]                    cnt_d;
  logic [HW-1:0]                    wb_base_q;
  logic [HW-1:0]                    rf_base_q;
  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_line_q;
  logic [LINE_WORDS*DATA_WIDTH-1:0] rf_line_q;
  logic                             req_ready_q;
  logic                             resp_valid_q;
  logic                             mem_en_q;
  logic                             mem_we_q;
  logic [ADDR_WIDTH-1:0]            mem_addr_q;
  logic [DATA_WIDTH-1:0]            mem_wdata_q;
  logic [ADDR_WIDTH-1:0]            wb_next_addr_d;
  logic [ADDR_WIDTH-1:0]            rf_next_addr_d;
  logic [DATA_WIDTH-1:0]            wb_next_word_d;
  logic                             unused_low_bits;

  // Next-word address/data; bases are line-aligned so the word index is
  // simply concatenated below them, which can never carry out of the line.
  always_comb begin
    cnt_d           = cnt_q + 1'b1;
    wb_next_addr_d  = {wb_base_q, cnt_d, 2'b00};
    rf_next_addr_d  = {rf_base_q, cnt_d, 2'b00};
    wb_next_word_d  = wb_line_q[DATA_WIDTH*int'(cnt_d) +: DATA_WIDTH];
    unused_low_bits = ^{wb_addr[OFS-1:0], rf_addr[OFS-1:0]};
  end

  // Output ports are driven straight from their registers.
  always_comb begin
    req_ready  = req_ready_q;
    resp_valid = resp_valid_q;
    rf_line    = rf_line_q;
    mem_en     = mem_en_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

  // Transfer sequencer with registered outputs: each word's address/data is
  // loaded on the edge that completes the previous word (or accepts the
  // request), so mem_en stays high between words with no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_base_q    <= '0;
      rf_base_q    <= '0;
      wb_line_q    <= '0;
      rf_line_q    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wb_base_q   <= wb_addr[ADDR_WIDTH-1:OFS];
            rf_base_q   <= rf_addr[ADDR_WIDTH-1:OFS];
            wb_line_q   <= wb_line;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            mem_en_q    <= 1'b1;
            if (req_wb) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {wb_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
              mem_wdata_q <= wb_line[DATA_WIDTH-1:0];
            end else begin
              state_q    <= RF;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {rf_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            cnt_q <= cnt_d;
            if (cnt_q == LAST) begin
              // cnt_d has wrapped to 0, so rf_next_addr_d is the refill base.
              state_q    <= RF;
              mem_we_q   <= 1'b0;
              mem_addr_q <= rf_next_addr_d;
            end else begin
              mem_addr_q  <= wb_next_addr_d;
              mem_wdata_q <= wb_next_word_d;
            end
          end
        end
        RF: begin
          if (mem_ready) begin
            rf_line_q[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] <= mem_rdata;
            cnt_q <= cnt_d;
            if (cnt_q == LAST) begin
              state_q      <= DONE;
              mem_en_q     <= 1'b0;
              resp_valid_q <= 1'b1;
            end else begin
              mem_addr_q <= rf_next_addr_d;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: randomized scoreboard bench for cache_mem_bridge.
// A request issuer pushes the expected memory words (with the cycle each
// must complete in) and the expected response into queues; a memory
// responder inserts wait states; a monitor pops and compares.
module tb_cache_mem_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int LB = LW * DW;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          start;
    int          done;
  } txn_t;

  typedef struct {
    int          acc;
    int          cyc;
    logic [LB-1:0] line;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wb = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [LB-1:0] wb_line = '0;
  logic [AW-1:0] rf_addr = '0;
  logic          resp_valid;
  logic [LB-1:0] rf_line;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready = 1'b0;

  txn_t  exp_mem[$];
  resp_t exp_resp[$];
  int    waits_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    last_acc = 0;
  int    prev_resp_cyc = 0;
  bit    have_prev = 1'b0;

  cache_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .wb_addr(wb_addr), .wb_line(wb_line), .rf_addr(rf_addr),
    .resp_valid(resp_valid), .rf_line(rf_line), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory contents are a fixed function of address; garbage when not ready.
  assign mem_rdata = mem_ready ? memf(mem_addr) : ~memf(mem_addr);

  task automatic check(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LW; i++) l[i*DW +: DW] = $urandom;
    return l;
  endfunction

  // Memory responder: per word, hold mem_ready low for the scheduled waits.
  int cur_wait = -1;
  always @(negedge clk) begin
    if (reset) begin
      cur_wait  = -1;
      mem_ready = 1'($urandom_range(1, 0));
    end else if (mem_en) begin
      if (cur_wait < 0) cur_wait = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
      if (cur_wait > 0) begin
        mem_ready = 1'b0;
        cur_wait--;
      end else begin
        mem_ready = 1'b1;
        cur_wait  = -1;
      end
    end else begin
      mem_ready = 1'($urandom_range(1, 0));
    end
  end

  // Monitor: compares presented memory words, idle behaviour and responses.
  txn_t          mon_t;
  resp_t         mon_r;
  logic [31:0]   last_addr = '0;
  logic [31:0]   last_wdata = '0;
  bit            exp_ready;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      last_addr  = '0;
      last_wdata = '0;
    end else begin
      exp_ready = (exp_resp.size() == 0) || (cyc <= exp_resp[0].acc);
      check("req_ready", req_ready, exp_ready);
      if (mem_en) begin
        if (exp_mem.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_mem: got we=%0b addr=%h, required no transaction (cycle %0d)",
                   mem_we, mem_addr, cyc);
        end else begin
          mon_t = exp_mem[0];
          check("mem_we", mem_we, mon_t.we);
          check("mem_addr", mem_addr, mon_t.addr);
          if (mon_t.we) check("mem_wdata", mem_wdata, mon_t.wdata);
          check("word_not_early", cyc >= mon_t.start, 1'b1);
          if (mem_ready) begin
            check("word_done_cycle", cyc, mon_t.done);
            void'(exp_mem.pop_front());
          end
        end
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
      end else begin
        check("idle_we", mem_we, 1'b0);
        check("idle_addr_hold", mem_addr, last_addr);
        check("idle_wdata_hold", mem_wdata, last_wdata);
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid=1, required 0 (cycle %0d)", cyc);
        end else begin
          mon_r = exp_resp.pop_front();
          check("resp_cycle", cyc, mon_r.cyc);
          check("rf_line", rf_line, mon_r.line);
        end
      end
    end
  end

  // Issue one request at a negedge; expectations derive from line-level rules.
  task automatic issue(input bit wb, input logic [31:0] wa, input logic [31:0] ra,
                       input logic [LB-1:0] line, input int wlo, input int whi,
                       input bit held);
    int n;
    int t;
    int w;
    txn_t x;
    resp_t r;
    logic [31:0] wbase;
    logic [31:0] rbase;
    n = 0;
    req_valid = held;
    req_wb = wb;
    wb_addr = wa;
    rf_addr = ra;
    wb_line = line;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
      return;
    end
    if (have_prev) check("accept_cycle", cyc, prev_resp_cyc + 1);
    req_valid = 1'b1;
    last_acc = cyc;
    t = cyc;
    wbase = wa & ~32'hF;
    rbase = ra & ~32'hF;
    if (wb) begin
      for (int i = 0; i < LW; i++) begin
        w = int'($urandom_range(whi, wlo));
        waits_q.push_back(w);
        x.we = 1'b1;
        x.addr = wbase + 32'(4 * i);
        x.wdata = line[i*DW +: DW];
        x.start = t + 1;
        x.done = t + 1 + w;
        t = x.done;
        exp_mem.push_back(x);
      end
    end
    r.line = '0;
    for (int i = 0; i < LW; i++) begin
      w = int'($urandom_range(whi, wlo));
      waits_q.push_back(w);
      x.we = 1'b0;
      x.addr = rbase + 32'(4 * i);
      x.wdata = '0;
      x.start = t + 1;
      x.done = t + 1 + w;
      t = x.done;
      exp_mem.push_back(x);
      r.line[i*DW +: DW] = memf(x.addr);
    end
    r.acc = last_acc;
    r.cyc = t + 1;
    exp_resp.push_back(r);
    prev_resp_cyc = r.cyc;
    have_prev = 1'b1;
    @(negedge clk);
    req_valid = held;
    req_wb = 1'($urandom_range(1, 0));
    wb_addr = $urandom;
    rf_addr = $urandom;
    wb_line = rand_line();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rf_line", rf_line, '0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'h0, 32'h0000_1234, rand_line(), 0, 0, 1'b0);
    issue(1'b1, 32'h0000_2000, 32'h0000_4010, rand_line(), 0, 0, 1'b0);
    issue(1'b0, $urandom, $urandom, rand_line(), 2, 2, 1'b0);

    // Reset during the third writeback word, then a normal request.
    issue(1'b1, $urandom, $urandom, rand_line(), 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_mem_en", mem_en, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_resp_valid", resp_valid, 1'b0);
    exp_mem.delete();
    exp_resp.delete();
    waits_q.delete();
    have_prev = 1'b0;
    @(negedge clk);
    #3 reset = 1'b0;
    issue(1'b1, $urandom, $urandom, rand_line(), 0, 1, 1'b0);

    // Back-to-back with req_valid held high across transfers.
    issue(1'b1, $urandom, $urandom, rand_line(), 0, 0, 1'b1);
    issue(1'b0, $urandom, $urandom, rand_line(), 0, 0, 1'b1);
    issue(1'b1, $urandom, $urandom, rand_line(), 0, 2, 1'b1);
    issue(1'b0, 32'h0, 32'hFFFF_FFF8, rand_line(), 0, 0, 1'b0);

    for (int k = 0; k < 40; k++)
      issue(1'($urandom_range(1, 0)), $urandom, $urandom, rand_line(), 0, 3,
            1'($urandom_range(1, 0)));
    req_valid = 1'b0;

    n = 0;
    while ((exp_mem.size() != 0 || exp_resp.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_mem", exp_mem.size(), 0);
    check("drain_resp", exp_resp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
